// File: rtl/running_average_decoder_if.sv
// Stream interface for running_average_decoder: averaged samples in, reconstructed samples out.
// The master drives the averages and flush; the slave (the decoder) returns samples and status.
interface running_average_decoder_if;
  logic        flush_i;
  logic        valid_i;
  logic [31:0] avg_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        primed_o;
  logic [31:0] count_o;

  modport master (
    output flush_i, valid_i, avg_i,
    input  valid_o, data_o, primed_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, avg_i,
    output valid_o, data_o, primed_o, count_o
  );
endinterface

// File: rtl/running_average_decoder.sv
// Inverse N-tap running-average filter: x = (avg << log2(N)) - sum of the last N-1 outputs, mod 2^32.
// Optional macro OUT_REG_EN adds one output register stage (latency 2 instead of 1).
module running_average_decoder #(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  running_average_decoder_if.slave bus
);

  localparam int SHIFT_N = $clog2(N);
  localparam logic [SHIFT_N-1:0] FILL_LAST = SHIFT_N'(N - 1);

  typedef enum logic {FILL, STEADY} state_t;

  state_t                 state_q, state_d;
  logic [SHIFT_N-1:0]     fill_q, fill_d;
  logic [N-2:0][31:0]     hist_q, hist_d;
  logic [31:0]            data_q, data_d;
  logic                   valid_q, valid_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            sum_hist;
  logic [31:0]            x;

  // Flush is applied first so a sample arriving with it decodes against empty history.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    hist_d   = hist_q;
    data_d   = data_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    sum_hist = '0;
    x        = '0;

    if (bus.flush_i) begin
      hist_d  = '0;
      count_d = '0;
      fill_d  = '0;
      state_d = FILL;
    end

    if (bus.valid_i) begin
      for (int i = 0; i < N - 1; i++) begin
        sum_hist = sum_hist + hist_d[i];
      end
      x = (bus.avg_i << SHIFT_N) - sum_hist;
      for (int i = N - 2; i > 0; i--) begin
        hist_d[i] = hist_d[i-1];
      end
      hist_d[0] = x;
      data_d    = x;
      valid_d   = 1'b1;
      count_d   = count_d + 32'd1;
      if (state_d == FILL) begin
        fill_d = fill_d + 1'b1;
        if (fill_d == FILL_LAST) begin
          state_d = STEADY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

`ifdef OUT_REG_EN
  logic        valid2_q, valid2_d;
  logic [31:0] data2_q, data2_d;
  logic [31:0] count2_q, count2_d;
  logic        primed2_q, primed2_d;

  // Status is delayed alongside the data so count/primed line up with each pulse.
  always_comb begin
    valid2_d  = valid_q && !bus.flush_i;
    data2_d   = valid_q ? data_q : data2_q;
    count2_d  = count_q;
    primed2_d = (state_q == STEADY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid2_q  <= 1'b0;
      data2_q   <= '0;
      count2_q  <= '0;
      primed2_q <= 1'b0;
    end else begin
      valid2_q  <= valid2_d;
      data2_q   <= data2_d;
      count2_q  <= count2_d;
      primed2_q <= primed2_d;
    end
  end

  assign bus.valid_o  = valid2_q;
  assign bus.data_o   = data2_q;
  assign bus.count_o  = count2_q;
  assign bus.primed_o = primed2_q;
`else
  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;
  assign bus.count_o  = count_q;
  assign bus.primed_o = (state_q == STEADY);
`endif

endmodule
